// File: rtl/vc_credit_tx.sv
// vc_credit_tx
//
// Credit-based link transmitter for four virtual channels (VCs). Each cycle at
// most one VC that is requesting and holds at least one downstream credit is
// granted, chosen round-robin from a priority pointer. The granted flit is
// registered onto the link one cycle later. Each VC keeps a credit counter
// that starts at BUF_DEPTH. A grant spends one credit, and a credit return
// from downstream restores one credit.
//
// Parameters
//   FLIT_W       flit payload width in bits
//   BUF_DEPTH    downstream per-VC buffer depth in flits (1..7)
//
// Ports
//   clk          single clock, rising edge
//   clr          asynchronous active-high reset
//   req          per-VC request, bit i = VC i presents a flit
//   req_flit     per-VC flit data, VC i in [i*FLIT_W +: FLIT_W]
//   grant        combinational one-hot (or zero) grant; the flit is taken when set
//   credit_valid downstream returns one credit this cycle
//   credit_vc    VC index of the returned credit
//   out_valid    registered link flit valid
//   out_vc       registered link flit VC index
//   out_flit     registered link flit payload
//   credit_cnt   per-VC credit counters, VC i in [3*i +: 3]
//   credit_err   sticky flag: a credit was returned to a full counter

module vc_credit_tx #(
    parameter int unsigned FLIT_W    = 16,
    parameter int unsigned BUF_DEPTH = 4
) (
    input  logic                clk,
    input  logic                clr,
    input  logic [3:0]          req,
    input  logic [4*FLIT_W-1:0] req_flit,
    output logic [3:0]          grant,
    input  logic                credit_valid,
    input  logic [1:0]          credit_vc,
    output logic                out_valid,
    output logic [1:0]          out_vc,
    output logic [FLIT_W-1:0]   out_flit,
    output logic [11:0]         credit_cnt,
    output logic                credit_err
);

    localparam int unsigned NUM_VC = 4;
    localparam int unsigned CNT_W  = 3;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BUF_DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]        ptr_q,       ptr_d;
    logic [CNT_W-1:0]  cnt_q [NUM_VC];
    logic [CNT_W-1:0]  cnt_d [NUM_VC];
    logic              out_valid_q, out_valid_d;
    logic [1:0]        out_vc_q,    out_vc_d;
    logic [FLIT_W-1:0] out_flit_q,  out_flit_d;
    logic              err_q,       err_d;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic [NUM_VC-1:0] eligible;
    logic [1:0]        cand;
    logic [1:0]        grant_idx;
    logic              grant_any;
    logic [NUM_VC-1:0] grant_vec;
    logic [FLIT_W-1:0] grant_flit;

    // Eligibility uses the registered counter, so a credit returned this
    // cycle cannot enable a grant until the next cycle.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_VC; i++) begin
            eligible[i] = req[i] && (cnt_q[i] != '0);
        end
    end

    // Scan VCs starting at ptr_q and take the first eligible one. The scan
    // never sees clr directly, so grant_any is masked separately below.
    always_comb begin
        cand      = ptr_q;
        grant_idx = ptr_q;
        grant_any = 1'b0;
        for (int k = 0; k < NUM_VC; k++) begin
            cand = ptr_q + 2'(k);
            if (!grant_any && eligible[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
        // Nothing is accepted while in reset.
        if (clr) begin
            grant_any = 1'b0;
        end
    end

    always_comb begin
        grant_vec = '0;
        if (grant_any) begin
            grant_vec[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        grant_flit = '0;
        for (int i = 0; i < NUM_VC; i++) begin
            if (grant_idx == 2'(i)) begin
                grant_flit = req_flit[i*FLIT_W +: FLIT_W];
            end
        end
    end

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        ptr_d = ptr_q;
        if (grant_any) begin
            ptr_d = grant_idx + 2'd1;
        end
    end

    // Per-VC credit accounting. A grant and a credit return on the same VC
    // cancel. The return is a no-op in that case, even when the counter is
    // full, because the grant frees the slot that the credit refills.
    always_comb begin
        err_d = err_q;
        for (int i = 0; i < NUM_VC; i++) begin
            logic spend;
            logic refill;
            spend    = grant_vec[i];
            refill   = credit_valid && (credit_vc == 2'(i));
            cnt_d[i] = cnt_q[i];
            unique case ({spend, refill})
                2'b10: cnt_d[i] = cnt_q[i] - 1'b1;
                2'b01: begin
                    if (cnt_q[i] < CNT_MAX) begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: cnt_d[i] = cnt_q[i];
            endcase
        end
    end

    // The link registers hold their payload on idle cycles. Only valid drops.
    always_comb begin
        out_valid_d = grant_any;
        out_vc_d    = out_vc_q;
        out_flit_d  = out_flit_q;
        if (grant_any) begin
            out_vc_d   = grant_idx;
            out_flit_d = grant_flit;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            ptr_q       <= 2'd0;
            out_valid_q <= 1'b0;
            out_vc_q    <= 2'd0;
            out_flit_q  <= '0;
            err_q       <= 1'b0;
            for (int i = 0; i < NUM_VC; i++) begin
                cnt_q[i] <= CNT_MAX;
            end
        end else begin
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_vc_q    <= out_vc_d;
            out_flit_q  <= out_flit_d;
            err_q       <= err_d;
            for (int i = 0; i < NUM_VC; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        credit_cnt = '0;
        for (int i = 0; i < NUM_VC; i++) begin
            credit_cnt[CNT_W*i +: CNT_W] = cnt_q[i];
        end
    end

    assign grant      = grant_vec;
    assign out_valid  = out_valid_q;
    assign out_vc     = out_vc_q;
    assign out_flit   = out_flit_q;
    assign credit_err = err_q;

endmodule

// File: doc/vc_credit_tx.md
VC_CREDIT_TX -- requirements
Module: vc_credit_tx

Interface
REQ-001 SHALL have parameter FLIT_W, default 16, flit payload width in bits.
REQ-002 SHALL have parameter BUF_DEPTH, default 4, downstream per-VC buffer depth in flits (range 1..7).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have port clr  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req  input  4  per-VC request; req[i]=1 means VC i presents a flit.
REQ-006 SHALL have port req_flit  input  4*FLIT_W  per-VC flit data; VC i occupies bits [i*FLIT_W +: FLIT_W].
REQ-007 SHALL have port grant  output  4  one-hot (or zero) combinational grant; flit accepted when grant[i]=1.
REQ-008 SHALL have port credit_valid  input  1  downstream returns one credit this cycle.
REQ-009 SHALL have port credit_vc  input  2  VC index of the returned credit.
REQ-010 SHALL have port out_valid  output  1  registered; link flit valid.
REQ-011 SHALL have port out_vc  output  2  registered; VC index of the link flit.
REQ-012 SHALL have port out_flit  output  FLIT_W  registered; link flit payload.
REQ-013 SHALL have port credit_cnt  output  4*3  per-VC credit counters; VC i in bits [3*i +: 3].
REQ-014 SHALL have port credit_err  output  1  sticky flag; credit returned to a full counter.

Function
REQ-015 SHALL treat VC i as eligible when req[i]=1 and credit counter i is nonzero.
REQ-016 SHALL grant at most one eligible VC per cycle, chosen round-robin starting from priority pointer ptr.
REQ-017 SHALL, after a grant to VC i, set ptr to (i+1) mod 4; ptr SHALL remain unchanged on cycles with no grant.
REQ-018 SHALL drive grant=4'b0000 when no VC is eligible.
REQ-019 SHALL, on a grant to VC i, register out_valid=1, out_vc=i, out_flit=req_flit slice i on the next posedge (latency 1 cycle).
REQ-020 SHALL register out_valid=0 on cycles with no grant; out_vc and out_flit SHALL hold their previous values.
REQ-021 SHALL decrement counter i by 1 on a grant to VC i.
REQ-022 SHALL increment counter credit_vc by 1 when credit_valid=1 and that counter is below BUF_DEPTH.
REQ-023 SHALL leave counter i unchanged when a grant to VC i and a credit return to VC i occur in the same cycle.
REQ-024 SHALL, on credit_valid=1 to a counter already at BUF_DEPTH with no same-cycle grant to that VC, hold the counter at BUF_DEPTH and set credit_err=1.
REQ-025 SHALL keep credit_err at 1 until clr is asserted.
REQ-026 SHALL never decrement a counter below 0; a VC at 0 credits SHALL NOT be granted regardless of req.
REQ-027 SHALL allow a credit returned this cycle to make a VC eligible no earlier than the next cycle (eligibility uses registered counter).
REQ-028 SHALL process grant, counter update, and credit return for different VCs independently in the same cycle.

Reset
REQ-029 SHALL, while clr=1, force asynchronously: out_valid=0, out_vc=0, out_flit=0, all counters=BUF_DEPTH, ptr=0, credit_err=0.
REQ-030 SHALL drive grant=4'b0000 while clr=1.
REQ-031 SHALL resume normal operation on the first posedge after clr deasserts, with VC0 highest priority.
REQ-032 SHALL discard any flit or credit presented in a cycle where clr is asserted, including mid-packet.

Verification
REQ-033 SHALL cover: reset then req=4'b1111 held 4 cycles -> grants VC0,VC1,VC2,VC3 in order; out_vc 0,1,2,3 one cycle later; each counter=3.
REQ-034 SHALL cover: req=4'b0001 held, no credits -> 4 grants to VC0, counter 4->0, then grant=0 and out_valid=0 while req stays 1.
REQ-035 SHALL cover: VC2 counter=0, credit_valid=1 credit_vc=2 -> counter=1 next cycle, grant[2]=1 on that cycle if req[2]=1.
REQ-036 SHALL cover: VC1 counter=2, same cycle grant[1]=1 and credit to VC1 -> counter stays 2.
REQ-037 SHALL cover: VC3 counter=4, credit to VC3 -> counter stays 4, credit_err=1, stays 1 until clr.
REQ-038 SHALL cover: clr pulsed asynchronously between edges mid-stream with counters 1,0,2,3 -> outputs zero immediately, counters read 4,4,4,4, ptr=0.
